// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [WIDTH-1:0]  instr_out;
  logic [ADDR_W-1:0] instr_wr_addr;
  logic              instr_wr_en;

  // master: the loader (consumes bytes, drives the memory write port)
  modport master (
    input  byte_in, byte_valid,
    output byte_ready, instr_out, instr_wr_addr, instr_wr_en
  );

  // slave: the byte source and the instruction memory
  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, instr_out, instr_wr_addr, instr_wr_en
  );
endinterface

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into words and strobes each completed word for one cycle.
module word_assembler
  import loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             accept_i,
  input  logic [7:0]       byte_i,
  output logic             lane_last_o,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o
);

  logic [LANE_W-1:0] lane_q;
  logic [WIDTH-1:0]  word_q;
  logic              valid_q;

  assign lane_last_o  = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values; blocking here would let valid_q see the updated lane.
      valid_q <= accept_i && lane_last_o;
      if (clear_i) begin
        lane_q <= '0;
      end else if (accept_i) begin
        lane_q <= lane_q + LANE_W'(1);
        // Shift right: after four bytes the first one sits in bits [7:0].
        word_q <= {byte_i, word_q[WIDTH-1:8]};
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Parses a framed byte image (count, payload, XOR checksum) into instruction-memory writes
// and holds the core in reset until a verified image is present.
module program_loader
  import loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  program_loader_if.master bus,
  output logic            core_reset,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int             LOGSIZE = $clog2(SIZE);
  localparam int             IDX_W   = LOGSIZE + 1;
  localparam logic [15:0]    SIZE16  = 16'(SIZE);

  loader_state_t    state_q, state_d;
  logic [7:0]       n_lo_q;
  logic [IDX_W-1:0] n_words_q;
  logic [IDX_W-1:0] word_idx_q;
  logic [7:0]       csum_q;

  logic        accept, data_accept, lane_last, last_byte, session_clear, word_valid;
  logic [15:0] hdr_n;
  logic        hdr_ok;

  assign accept      = bus.byte_valid && bus.byte_ready;
  assign data_accept = (state_q == ST_DATA) && accept;
  assign hdr_n       = {bus.byte_in, n_lo_q};
  assign hdr_ok      = (hdr_n != 16'd0) && (hdr_n <= SIZE16);
  // The word index still names the word being assembled until its write cycle ends.
  assign last_byte   = data_accept && lane_last && ((word_idx_q + IDX_W'(1)) == n_words_q);

  always_comb begin
    // NOTE: default first so every path assigns state_d; a missing branch would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_HDR_LO;
      ST_HDR_LO: if (accept) state_d = ST_HDR_HI;
      ST_HDR_HI: if (accept) state_d = hdr_ok ? ST_DATA : ST_ERROR;
      ST_DATA:   if (last_byte) state_d = ST_CHECK;
      ST_CHECK:  if (accept) state_d = (bus.byte_in == csum_q) ? ST_DONE : ST_ERROR;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign session_clear = (state_d == ST_HDR_LO) && (state_q != ST_HDR_LO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      n_lo_q     <= '0;
      n_words_q  <= '0;
      word_idx_q <= '0;
      csum_q     <= '0;
    end else begin
      state_q <= state_d;
      if (session_clear) begin
        word_idx_q <= '0;
        csum_q     <= '0;
      end else begin
        if (word_valid)  word_idx_q <= word_idx_q + IDX_W'(1);
        if (data_accept) csum_q     <= csum_q ^ bus.byte_in;
      end
      if ((state_q == ST_HDR_LO) && accept) n_lo_q    <= bus.byte_in;
      if ((state_q == ST_HDR_HI) && accept) n_words_q <= IDX_W'(hdr_n);
    end
  end

  word_assembler #(.WIDTH(WIDTH)) u_word_assembler (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (session_clear),
    .accept_i     (data_accept),
    .byte_i       (bus.byte_in),
    .lane_last_o  (lane_last),
    .word_o       (bus.instr_out),
    .word_valid_o (word_valid)
  );

  assign busy       = state_q inside {ST_HDR_LO, ST_HDR_HI, ST_DATA, ST_CHECK};
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign core_reset = !done;

  assign bus.byte_ready    = busy;
  assign bus.instr_wr_en   = word_valid;
  assign bus.instr_wr_addr = {word_idx_q[LOGSIZE-1:0], 2'b00};

endmodule
